rr_sel_arb: RTL and testbench

- Round-robin arbiter that generates the one-hot select vector for the downstream one-hot AND-OR mux, which is the bit-wise select/OR stage.
- Arbitrates N requesters onto one shared datapath using a valid/ready handshake.
- Supports multi-beat transfers: the winning requester keeps the grant until its last beat is accepted.
- Sits directly upstream of the mux. o_sel drives the mux's select input, and requester data feeds the mux's N-input data vector.

---
 rtl/rr_sel_arb.sv | 154 +++++++++++++++
 tb/tb_rr_sel_arb.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_sel_arb.sv
`default_nettype none
// ============================================================================
// Module   : rr_sel_arb
// Purpose  : Round-robin arbiter that produces the one-hot select vector for a
//            downstream one-hot AND-OR mux. N requesters share one datapath
//            through a valid/ready handshake. A multi-beat packet keeps its
//            grant until its last beat is accepted.
// Ports    : clk     - clock
//            rst     - asynchronous active-high reset
//            i_req   - per-requester valid (beat pending)
//            i_last  - per-requester last-beat flag (used for the winner only)
//            i_rdy   - downstream accepts the muxed beat this cycle
//            o_ack   - one-hot beat-accepted strobe (o_sel & i_rdy)
//            o_sel   - one-hot grant, zero when idle (drives mux select)
//            o_idx   - binary index of the o_sel bit, zero when idle
//            o_vld   - a grant is active
//            o_lock  - multi-beat transfer in progress (registered)
// Revision : 1.0 - initial release
// ============================================================================
module rr_sel_arb #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     i_req,
    input  logic [N-1:0]     i_last,
    input  logic             i_rdy,
    output logic [N-1:0]     o_ack,
    output logic [N-1:0]     o_sel,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_vld,
    output logic             o_lock
);

    typedef enum logic [0:0] {
        ST_OPEN = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_owner;

    logic [N-1:0]     w_rr_sel;
    logic [IDX_W-1:0] w_rr_idx;
    logic             w_rr_hit;
    logic [N-1:0]     w_own_hot;
    logic [N-1:0]     w_sel;
    logic [IDX_W-1:0] w_idx;
    logic             w_xfer;
    logic             w_last;
    logic [IDX_W-1:0] w_ptr_nxt;

    // Circular priority scan starting at r_ptr. The position is folded back
    // explicitly so that non-power-of-two N wraps at N rather than 2**IDX_W.
    always_comb begin : p_rr_scan
        int               v_pos;
        logic [IDX_W-1:0] v_i;
        w_rr_sel = '0;
        w_rr_idx = '0;
        w_rr_hit = 1'b0;
        v_pos    = 0;
        v_i      = '0;
        for (int k = 0; k < N; k++) begin
            v_pos = int'(r_ptr) + k;
            if (v_pos >= N) begin
                v_pos = v_pos - N;
            end
            v_i = IDX_W'(v_pos);
            if (!w_rr_hit && i_req[v_i]) begin
                w_rr_hit    = 1'b1;
                w_rr_sel    = '0;
                w_rr_sel[v_i] = 1'b1;
                w_rr_idx    = v_i;
            end
        end
    end

    assign w_own_hot = {{(N-1){1'b0}}, 1'b1} << r_owner;

    // While locked only the owner may be selected; if the owner drops its
    // request mid-packet the grant goes to zero but the lock is kept.
    always_comb begin : p_sel
        w_sel = '0;
        w_idx = '0;
        if (r_state == ST_LOCK) begin
            w_sel = w_own_hot & i_req;
            w_idx = (|w_sel) ? r_owner : '0;
        end else begin
            w_sel = w_rr_sel;
            w_idx = w_rr_idx;
        end
    end

    assign w_xfer    = (|w_sel) & i_rdy;
    assign w_last    = i_last[w_idx];
    assign w_ptr_nxt = (w_idx == IDX_W'(N-1)) ? '0 : (w_idx + IDX_W'(1));

    // Pointer moves only on an accepted last beat; a non-last beat taken
    // while open locks the winner in, later non-last beats change nothing.
    always_ff @(posedge clk or posedge rst) begin : p_state
        if (rst) begin
            r_state <= ST_OPEN;
            r_ptr   <= '0;
            r_owner <= '0;
        end else if (w_xfer) begin
            if (w_last) begin
                r_state <= ST_OPEN;
                r_ptr   <= w_ptr_nxt;
            end else if (r_state == ST_OPEN) begin
                r_state <= ST_LOCK;
                r_owner <= w_idx;
            end
        end
    end

    assign o_sel  = w_sel;
    assign o_idx  = w_idx;
    assign o_vld  = |w_sel;
    assign o_ack  = i_rdy ? w_sel : '0;
    assign o_lock = (r_state == ST_LOCK);

`ifndef SYNTHESIS
    // Simulation-only protocol checks.
    logic         r_chk_stall;
    logic [N-1:0] r_chk_req;
    logic [N-1:0] r_chk_sel;

    always_ff @(posedge clk or posedge rst) begin : p_chk
        if (rst) begin
            r_chk_stall <= 1'b0;
            r_chk_req   <= '0;
            r_chk_sel   <= '0;
        end else begin
            a_onehot: assert ($onehot0(o_sel))
                else $error("o_sel not onehot0: %b", o_sel);
            if (r_chk_stall && (i_req == r_chk_req)) begin
                a_stable: assert (o_sel == r_chk_sel)
                    else $error("o_sel changed under stall: %b -> %b", r_chk_sel, o_sel);
            end
            if (r_state == ST_LOCK) begin
                a_owner: assert ((o_sel & ~w_own_hot) == '0)
                    else $error("o_sel %b outside owner %0d", o_sel, r_owner);
            end
            r_chk_stall <= o_vld & ~i_rdy;
            r_chk_req   <= i_req;
            r_chk_sel   <= o_sel;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_sel_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_sel_arb
// Purpose  : Self-checking bench for rr_sel_arb. A behavioural model tracks
//            pointer/lock/owner and picks the winner as the requester with the
//            smallest circular distance from the pointer. Directed sequences
//            pin the model with literal expectations, then random traffic
//            (including occasional mid-cycle resets) is checked every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_sel_arb;

    localparam int N     = 4;
    localparam int IDX_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     i_req;
    logic [N-1:0]     i_last;
    logic             i_rdy;
    logic [N-1:0]     o_ack;
    logic [N-1:0]     o_sel;
    logic [IDX_W-1:0] o_idx;
    logic             o_vld;
    logic             o_lock;

    int n_checks = 0;
    int n_fail   = 0;

    int m_ptr   = 0;
    int m_lock  = 0;
    int m_owner = 0;

    rr_sel_arb #(.N(N)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .i_req  (i_req),
        .i_last (i_last),
        .i_rdy  (i_rdy),
        .o_ack  (o_ack),
        .o_sel  (o_sel),
        .o_idx  (o_idx),
        .o_vld  (o_vld),
        .o_lock (o_lock)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req_v);
        n_checks++;
        if (act != req_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req_v, $time);
        end
    endtask

    // Winner index from the model state, or -1 when nothing is granted.
    function automatic int exp_idx(input int req);
        int best;
        int bestd;
        best  = -1;
        bestd = N;
        if (m_lock != 0) begin
            return (((req >> m_owner) & 1) != 0) ? m_owner : -1;
        end
        for (int j = 0; j < N; j++) begin
            if (((req >> j) & 1) != 0) begin
                int d;
                d = (j - m_ptr + N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best  = j;
                end
            end
        end
        return best;
    endfunction

    // Model state update on the same edges the DUT sees.
    always @(posedge clk or posedge rst) begin
        int w;
        if (rst) begin
            m_ptr   <= 0;
            m_lock  <= 0;
            m_owner <= 0;
        end else begin
            w = exp_idx(int'(i_req));
            if (w >= 0 && i_rdy) begin
                if (((int'(i_last) >> w) & 1) != 0) begin
                    m_lock <= 0;
                    m_ptr  <= (w + 1) % N;
                end else if (m_lock == 0) begin
                    m_lock  <= 1;
                    m_owner <= w;
                end
            end
        end
    end

    // Per-cycle compare against the model, well away from the rising edge.
    always @(negedge clk) begin
        int w;
        int es;
        #2;
        if (!rst) begin
            w  = exp_idx(int'(i_req));
            es = (w >= 0) ? (1 << w) : 0;
            chk("model_sel",  int'(o_sel),  es);
            chk("model_idx",  int'(o_idx),  (w >= 0) ? w : 0);
            chk("model_vld",  int'(o_vld),  (w >= 0) ? 1 : 0);
            chk("model_ack",  int'(o_ack),  i_rdy ? es : 0);
            chk("model_lock", int'(o_lock), m_lock);
        end
    end

    task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, input logic d);
        @(negedge clk);
        i_req  = r;
        i_last = l;
        i_rdy  = d;
        #3;
    endtask

    initial begin
        rst    = 1'b1;
        i_req  = '0;
        i_last = '0;
        i_rdy  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset then idle
        step(4'b0000, 4'b0000, 1'b1);
        chk("idle_sel",  int'(o_sel),  0);
        chk("idle_vld",  int'(o_vld),  0);
        chk("idle_idx",  int'(o_idx),  0);
        chk("idle_lock", int'(o_lock), 0);
        chk("idle_ack",  int'(o_ack),  0);

        // Round robin over all requesters, single-beat packets
        for (int k = 0; k < 5; k++) begin
            step(4'b1111, 4'b1111, 1'b1);
            chk("rr_idx", int'(o_idx), k % 4);
            chk("rr_ack", int'(o_ack), 1 << (k % 4));
        end

        // Backpressure: ptr=1, requesters 1 and 2 pending
        for (int k = 0; k < 3; k++) begin
            step(4'b0110, 4'b1111, 1'b0);
            chk("bp_sel", int'(o_sel), 2);
            chk("bp_ack", int'(o_ack), 0);
        end
        step(4'b0110, 4'b1111, 1'b1);
        chk("bp_rel_ack", int'(o_ack), 2);
        step(4'b0110, 4'b1111, 1'b1);
        chk("bp_next_sel", int'(o_sel), 4);

        // Bring ptr back to 0 (requester 3 finishes)
        step(4'b1000, 4'b1111, 1'b1);
        chk("wrap_idx", int'(o_idx), 3);

        // Multi-beat packet from requester 0
        step(4'b1111, 4'b1110, 1'b1);
        chk("mb1_sel",  int'(o_sel),  1);
        chk("mb1_lock", int'(o_lock), 0);
        step(4'b1111, 4'b1110, 1'b1);
        chk("mb2_sel",  int'(o_sel),  1);
        chk("mb2_lock", int'(o_lock), 1);
        step(4'b1111, 4'b1111, 1'b1);
        chk("mb3_sel",  int'(o_sel),  1);
        chk("mb3_lock", int'(o_lock), 1);
        step(4'b1111, 4'b1111, 1'b0);
        chk("mb_after_sel",  int'(o_sel),  2);
        chk("mb_after_lock", int'(o_lock), 0);

        // Lock held across an owner gap (owner = 2)
        step(4'b0100, 4'b0000, 1'b1);
        chk("gap_first_sel", int'(o_sel), 4);
        for (int k = 0; k < 2; k++) begin
            step(4'b1011, 4'b1111, 1'b1);
            chk("gap_sel",  int'(o_sel),  0);
            chk("gap_vld",  int'(o_vld),  0);
            chk("gap_lock", int'(o_lock), 1);
        end
        step(4'b1111, 4'b0100, 1'b1);
        chk("gap_end_ack",  int'(o_ack),  4);
        chk("gap_end_lock", int'(o_lock), 1);
        step(4'b1111, 4'b1111, 1'b0);
        chk("gap_next_idx",  int'(o_idx),  3);
        chk("gap_next_lock", int'(o_lock), 0);

        // Async reset in the middle of a packet owned by requester 1
        step(4'b1000, 4'b1111, 1'b1);
        step(4'b0010, 4'b0000, 1'b1);
        chk("ar_win_idx", int'(o_idx), 1);
        step(4'b1111, 4'b1111, 1'b0);
        chk("ar_lock_pre", int'(o_lock), 1);
        chk("ar_sel_pre",  int'(o_sel),  2);
        #1;
        rst = 1'b1;
        #1;
        chk("ar_lock_now", int'(o_lock), 0);
        chk("ar_sel_now",  int'(o_sel),  1);
        @(negedge clk);
        rst = 1'b0;
        step(4'b1110, 4'b1111, 1'b0);
        chk("ar_after_idx", int'(o_idx), 1);

        // Randomized traffic with occasional asynchronous reset pulses
        for (int k = 0; k < 3000; k++) begin
            logic [N-1:0] r;
            logic [N-1:0] l;
            logic         d;
            r = 4'($urandom_range(0, 15));
            l = ($urandom_range(0, 2) == 0) ? 4'b1111 : 4'($urandom_range(0, 15));
            d = ($urandom_range(0, 3) != 0);
            step(r, l, d);
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                #1;
                chk("rand_rst_lock", int'(o_lock), 0);
                rst = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
